// File: rtl/fractcam_entry_wr.sv
// fractcam_entry_wr: write-side controller for the FractCAM LUT-based TCAM.
// A (key, mask) rule for one entry becomes 64 LUT-RAM write cycles, one per
// 6-bit search value, with every key slice written in parallel. The block
// also owns the per-entry valid vector that qualifies the match lines.
//
// Optional build macro: FRACTCAM_WR_QUEUE_EN adds a 2-entry in-order request
// FIFO in front of the FSM, so requests can be accepted during a sweep.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   wr_valid/wr_ready           request handshake
//   wr_op                       0 = write rule, 1 = delete entry
//   wr_addr, wr_key, wr_mask    target entry, rule key, care mask (1 = compare)
//   lut_we, lut_wentry          LUT-RAM write enable and entry (column)
//   lut_waddr, lut_wdata        search value and one match bit per slice
//   entry_vld                   per-entry valid bits
//   busy, done                  sweep in progress, one-cycle completion pulse
module fractcam_entry_wr #(
  parameter int unsigned KEY_WIDTH = 48,
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned ADDR_W    = $clog2(DEPTH),
  localparam int unsigned NUM_SLICE = (KEY_WIDTH + 5) / 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic                 wr_op,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [KEY_WIDTH-1:0] wr_key,
  input  logic [KEY_WIDTH-1:0] wr_mask,
  output logic                 lut_we,
  output logic [ADDR_W-1:0]    lut_wentry,
  output logic [5:0]           lut_waddr,
  output logic [NUM_SLICE-1:0] lut_wdata,
  output logic [DEPTH-1:0]     entry_vld,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned PAD_W = NUM_SLICE * 6;

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t                 state;
  logic [PAD_W-1:0]       key_q;
  logic [PAD_W-1:0]       mask_q;

  // Request presented to the FSM (direct inputs or FIFO head)
  logic                   req_go;
  logic                   req_op;
  logic [ADDR_W-1:0]      req_addr;
  logic [KEY_WIDTH-1:0]   req_key;
  logic [KEY_WIDTH-1:0]   req_mask;
  logic [PAD_W-1:0]       req_key_p;
  logic [PAD_W-1:0]       req_mask_p;
  logic                   addr_ok;

  // Zero padding of the mask makes bits above KEY_WIDTH don't-care
  assign req_key_p  = PAD_W'(req_key);
  assign req_mask_p = PAD_W'(req_mask);
  assign addr_ok    = (32'(req_addr) < DEPTH);

  // One match bit per slice for search value a
  function automatic logic [NUM_SLICE-1:0] slice_match(input logic [5:0]       a,
                                                       input logic [PAD_W-1:0] k,
                                                       input logic [PAD_W-1:0] m);
    logic [NUM_SLICE-1:0] r;
    r = '0;
    for (int unsigned s = 0; s < NUM_SLICE; s++) begin
      r[s] = ((a ^ k[6*s +: 6]) & m[6*s +: 6]) == 6'd0;
    end
    return r;
  endfunction

`ifdef FRACTCAM_WR_QUEUE_EN
  typedef struct packed {
    logic                 op;
    logic [ADDR_W-1:0]    addr;
    logic [KEY_WIDTH-1:0] key;
    logic [KEY_WIDTH-1:0] mask;
  } req_t;

  req_t       fifo_mem [2];
  logic       rd_ptr;
  logic       wr_ptr;
  logic [1:0] fifo_cnt;
  logic [1:0] fifo_cnt_nxt;
  logic       push;
  logic       pop;

  assign push         = wr_valid && wr_ready;
  assign pop          = (state == IDLE) && (fifo_cnt != 2'd0);
  assign fifo_cnt_nxt = fifo_cnt + 2'(push) - 2'(pop);

  assign req_go   = pop;
  assign req_op   = fifo_mem[rd_ptr].op;
  assign req_addr = fifo_mem[rd_ptr].addr;
  assign req_key  = fifo_mem[rd_ptr].key;
  assign req_mask = fifo_mem[rd_ptr].mask;

  // FIFO storage (payload only, no reset needed)
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{op: wr_op, addr: wr_addr, key: wr_key, mask: wr_mask};
    end
  end

  // FIFO pointers, occupancy and ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
      wr_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt_nxt;
      wr_ready <= (fifo_cnt_nxt != 2'd2);
    end
  end
`else
  logic start_sweep;
  logic sweep_end;

  assign req_go      = wr_valid && wr_ready && (state == IDLE);
  assign req_op      = wr_op;
  assign req_addr    = wr_addr;
  assign req_key     = wr_key;
  assign req_mask    = wr_mask;
  assign start_sweep = req_go && !req_op && addr_ok;
  assign sweep_end   = (state == SWEEP) && (lut_waddr == 6'd63);

  // Ready drops at the accepting edge of a write and returns when its sweep ends
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ready <= 1'b0;
    end else begin
      wr_ready <= (state == IDLE) ? !start_sweep : sweep_end;
    end
  end
`endif

  // Sweep FSM with registered LUT write port and valid vector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lut_we     <= 1'b0;
      lut_wentry <= '0;
      lut_waddr  <= '0;
      lut_wdata  <= '0;
      entry_vld  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      key_q      <= '0;
      mask_q     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_go) begin
            if (!addr_ok) begin
              done <= 1'b1;
            end else if (req_op) begin
              entry_vld[req_addr] <= 1'b0;
              done                <= 1'b1;
            end else begin
              // Entry stays invalid until its last LUT word is written
              entry_vld[req_addr] <= 1'b0;
              key_q               <= req_key_p;
              mask_q              <= req_mask_p;
              lut_wentry          <= req_addr;
              lut_waddr           <= 6'd0;
              lut_wdata           <= slice_match(6'd0, req_key_p, req_mask_p);
              lut_we              <= 1'b1;
              busy                <= 1'b1;
              state               <= SWEEP;
            end
          end
        end
        SWEEP: begin
          lut_waddr <= lut_waddr + 6'd1;
          if (lut_waddr == 6'd63) begin
            lut_we                <= 1'b0;
            busy                  <= 1'b0;
            lut_wdata             <= '0;
            entry_vld[lut_wentry] <= 1'b1;
            done                  <= 1'b1;
            state                 <= IDLE;
          end else begin
            lut_wdata <= slice_match(lut_waddr + 6'd1, key_q, mask_q);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
